// File: rtl/cnn_pkg.sv
// Shared dimensions, width helpers and state encoding for the CNN pad feeder.
package cnn_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int padded_dim(input int n, input int p);
        return n + 2 * p;
    endfunction

    // Number of stride-aligned K-wide windows along one padded axis.
    function automatic int out_dim(input int n, input int k, input int p, input int s);
        return (n + 2 * p - k) / s + 1;
    endfunction

    // Width able to index 0..n-1.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width able to hold 0..n, used where a bound equal to n is compared.
    function automatic int ctr_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cnn_pos_counter.sv
// Wrap counter over 0..pMODULO-1 with a mod-S phase, a stride-alignment flag
// and a running count of aligned positions already passed in this sweep.
module cnn_pos_counter #(
    parameter int pMODULO = 6,
    parameter int pSTRIDE = 1,
    parameter int pOFFSET = 2,
    parameter int pVAL_W  = 3,
    parameter int pIDX_W  = 2,
    parameter int pPH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    output logic [pVAL_W-1:0] value,
    output logic [pIDX_W-1:0] index,
    output logic              last,
    output logic              aligned
);

    localparam logic [pVAL_W-1:0] LAST_V   = pVAL_W'(pMODULO - 1);
    localparam logic [pVAL_W-1:0] OFF_V    = pVAL_W'(pOFFSET);
    localparam logic [pPH_W-1:0]  PH_LAST  = pPH_W'(pSTRIDE - 1);
    localparam logic [pPH_W-1:0]  PH_ALIGN = pPH_W'(pOFFSET % pSTRIDE);

    logic [pPH_W-1:0] phase;

    assign last    = (value == LAST_V);
    // phase == value mod S, so alignment to (value-OFFSET) mod S == 0 needs no divider.
    assign aligned = (value >= OFF_V) && (phase == PH_ALIGN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            phase <= '0;
            index <= '0;
        end else if (clear) begin
            value <= '0;
            phase <= '0;
            index <= '0;
        end else if (en) begin
            if (last) begin
                value <= '0;
                phase <= '0;
                index <= '0;
            end else begin
                value <= value + 1'b1;
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                index <= index + pIDX_W'(aligned);
            end
        end
    end

endmodule

// File: rtl/cnn_pad_feeder.sv
// Inserts a zero border around an unpadded raster stream, feeds the K x K line
// buffer and flags each beat that completes a stride-aligned receptive field.
module cnn_pad_feeder
    import cnn_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pINPUT_WIDTH  = 640,
    parameter int pINPUT_HEIGHT = 480,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1,
    parameter int pSTRIDE       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pDATA_WIDTH-1:0] in_data,
    input  logic                   out_ready,
    output logic                   out_en,
    output logic [pDATA_WIDTH-1:0] out_data,
    output logic                   win_valid,
    output logic [idx_w(out_dim(pINPUT_HEIGHT, pKERNEL_SIZE, pPADDING, pSTRIDE))-1:0] win_row,
    output logic [idx_w(out_dim(pINPUT_WIDTH, pKERNEL_SIZE, pPADDING, pSTRIDE))-1:0]  win_col,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int WP  = padded_dim(pINPUT_WIDTH, pPADDING);
    localparam int HP  = padded_dim(pINPUT_HEIGHT, pPADDING);
    localparam int WO  = out_dim(pINPUT_WIDTH, pKERNEL_SIZE, pPADDING, pSTRIDE);
    localparam int HO  = out_dim(pINPUT_HEIGHT, pKERNEL_SIZE, pPADDING, pSTRIDE);
    localparam int CW  = ctr_w(WP);
    localparam int RW  = ctr_w(HP);
    localparam int OCW = idx_w(WO);
    localparam int ORW = idx_w(HO);
    localparam int PHW = idx_w(pSTRIDE);

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [OCW-1:0] col_idx;
    logic [ORW-1:0] row_idx;
    logic           col_last;
    logic           row_last;
    logic           col_aligned;
    logic           row_aligned;
    logic           padded;
    logic           last_pos;
    logic           clear;

    assign padded = (int'(row) < pPADDING) || (int'(row) >= pPADDING + pINPUT_HEIGHT) ||
                    (int'(col) < pPADDING) || (int'(col) >= pPADDING + pINPUT_WIDTH);
    assign last_pos = col_last && row_last;
    assign clear    = (state == IDLE) && start;
    assign busy     = (state == ACTIVE);

    cnn_pos_counter #(
        .pMODULO(WP), .pSTRIDE(pSTRIDE), .pOFFSET(pKERNEL_SIZE - 1),
        .pVAL_W(CW), .pIDX_W(OCW), .pPH_W(PHW)
    ) u_col (
        .clk(clk), .rst(rst), .clear(clear), .en(out_en),
        .value(col), .index(col_idx), .last(col_last), .aligned(col_aligned)
    );

    cnn_pos_counter #(
        .pMODULO(HP), .pSTRIDE(pSTRIDE), .pOFFSET(pKERNEL_SIZE - 1),
        .pVAL_W(RW), .pIDX_W(ORW), .pPH_W(PHW)
    ) u_row (
        .clk(clk), .rst(rst), .clear(clear), .en(out_en && col_last),
        .value(row), .index(row_idx), .last(row_last), .aligned(row_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Handshake: a pixel transfers on in_valid && in_ready; a beat is any cycle
    // with out_en, which requires out_ready and either a border slot or a pixel.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_en     = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                if (start) next_state = ACTIVE;
            end
            ACTIVE: begin
                in_ready = out_ready && !padded;
                out_en   = out_ready && (padded || in_valid);
                if (!padded) out_data = in_data;
                if (out_en && last_pos) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One cycle behind the beat, lining up with the buffer's registered window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= out_en && col_aligned && row_aligned;
            frame_done <= out_en && last_pos;
            if (out_en && col_aligned && row_aligned) begin
                win_row <= row_idx;
                win_col <= col_idx;
            end
        end
    end

endmodule

// File: tb/tb_cnn_pad_feeder.sv
// Three feeder configurations (P=1/S=1, P=1/S=2, P=0/S=1) run side by side
// against a cycle model and a window-coordinate scoreboard.
module tb_cnn_pad_feeder;
    import cnn_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int K = 3;
    localparam int A_RW = idx_w(out_dim(H, K, 1, 1));
    localparam int A_CW = idx_w(out_dim(W, K, 1, 1));
    localparam int B_RW = idx_w(out_dim(H, K, 1, 2));
    localparam int B_CW = idx_w(out_dim(W, K, 1, 2));
    localparam int C_RW = idx_w(out_dim(H, K, 0, 1));
    localparam int C_CW = idx_w(out_dim(W, K, 0, 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic iv [3];
    logic [7:0] din [3];
    logic ir [3];
    logic oe [3];
    logic [7:0] dout [3];
    logic wv_o [3];
    logic busy_o [3];
    logic fd_o [3];
    logic [A_RW-1:0] a_wr;
    logic [A_CW-1:0] a_wc;
    logic [B_RW-1:0] b_wr;
    logic [B_CW-1:0] b_wc;
    logic [C_RW-1:0] c_wr;
    logic [C_CW-1:0] c_wc;

    always #5 clk = ~clk;

    cnn_pad_feeder #(.pDATA_WIDTH(8), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
        .pKERNEL_SIZE(K), .pPADDING(1), .pSTRIDE(1)) u_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0]), .out_ready(out_ready), .out_en(oe[0]), .out_data(dout[0]),
        .win_valid(wv_o[0]), .win_row(a_wr), .win_col(a_wc), .busy(busy_o[0]),
        .frame_done(fd_o[0]));

    cnn_pad_feeder #(.pDATA_WIDTH(8), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
        .pKERNEL_SIZE(K), .pPADDING(1), .pSTRIDE(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1]), .out_ready(out_ready), .out_en(oe[1]), .out_data(dout[1]),
        .win_valid(wv_o[1]), .win_row(b_wr), .win_col(b_wc), .busy(busy_o[1]),
        .frame_done(fd_o[1]));

    cnn_pad_feeder #(.pDATA_WIDTH(8), .pINPUT_WIDTH(W), .pINPUT_HEIGHT(H),
        .pKERNEL_SIZE(K), .pPADDING(0), .pSTRIDE(1)) u_c (
        .clk(clk), .rst(rst), .start(start), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[2]), .out_ready(out_ready), .out_en(oe[2]), .out_data(dout[2]),
        .win_valid(wv_o[2]), .win_row(c_wr), .win_col(c_wc), .busy(busy_o[2]),
        .frame_done(fd_o[2]));

    int p_w [3] = '{W, W, W};
    int p_h [3] = '{H, H, H};
    int p_k [3] = '{K, K, K};
    int p_p [3] = '{1, 1, 0};
    int p_s [3] = '{1, 2, 1};

    bit m_act [3];
    int m_r [3];
    int m_c [3];
    int m_pix [3];
    bit m_wv [3];
    int m_wr [3];
    int m_wc [3];
    bit m_fd [3];
    int wcnt [3];
    logic [7:0] tab [3][64];
    int vmode [3];
    bit rand_rdy;
    int cyc;
    int n_assert;
    int n_fail;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input int inst, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_r[i] = 0; m_c[i] = 0; m_pix[i] = 0;
            m_wv[i] = 0; m_wr[i] = 0; m_wc[i] = 0; m_fd[i] = 0; wcnt[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        int o_wr [3];
        int o_wc [3];
        o_wr[0] = int'(a_wr); o_wr[1] = int'(b_wr); o_wr[2] = int'(c_wr);
        o_wc[0] = int'(a_wc); o_wc[1] = int'(b_wc); o_wc[2] = int'(c_wc);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_busy"}, i, int'(busy_o[i]), 0);
            chk({tag, "_win_valid"}, i, int'(wv_o[i]), 0);
            chk({tag, "_win_row"}, i, o_wr[i], 0);
            chk({tag, "_win_col"}, i, o_wc[i], 0);
            chk({tag, "_frame_done"}, i, int'(fd_o[i]), 0);
            chk({tag, "_out_en"}, i, int'(oe[i]), 0);
            chk({tag, "_in_ready"}, i, int'(ir[i]), 0);
        end
    endtask

    // One clock: drive inputs at negedge, check, then advance the model over the posedge.
    task automatic step(input logic st, input logic ordy_in);
        logic ordy;
        int o_wr [3];
        int o_wc [3];
        int wp, hp, wo, ho, idx, left;
        bit pad, en, nwv;
        @(negedge clk);
        ordy = rand_rdy ? ($urandom_range(0, 4) != 0) : ordy_in;
        start = st;
        out_ready = ordy;
        for (int i = 0; i < 3; i++) begin
            case (vmode[i])
                0:       iv[i] = 1'b1;
                1:       iv[i] = (cyc % 2 == 0);
                default: iv[i] = ($urandom_range(0, 2) != 0);
            endcase
            din[i] = (m_pix[i] < p_w[i] * p_h[i]) ? tab[i][m_pix[i]] : 8'($urandom);
        end
        cyc++;
        #1;
        o_wr[0] = int'(a_wr); o_wr[1] = int'(b_wr); o_wr[2] = int'(c_wr);
        o_wc[0] = int'(a_wc); o_wc[1] = int'(b_wc); o_wc[2] = int'(c_wc);
        for (int i = 0; i < 3; i++) begin
            wp = p_w[i] + 2 * p_p[i];
            hp = p_h[i] + 2 * p_p[i];
            wo = (wp - p_k[i]) / p_s[i] + 1;
            ho = (hp - p_k[i]) / p_s[i] + 1;
            pad = (m_r[i] < p_p[i]) || (m_r[i] >= p_p[i] + p_h[i]) ||
                  (m_c[i] < p_p[i]) || (m_c[i] >= p_p[i] + p_w[i]);
            en = m_act[i] && ordy && (pad || iv[i]);

            chk("busy", i, int'(busy_o[i]), int'(m_act[i]));
            chk("win_valid", i, int'(wv_o[i]), int'(m_wv[i]));
            chk("win_row", i, o_wr[i], m_wr[i]);
            chk("win_col", i, o_wc[i], m_wc[i]);
            chk("frame_done", i, int'(fd_o[i]), int'(m_fd[i]));
            chk("in_ready", i, int'(ir[i]), int'(m_act[i] && ordy && !pad));
            chk("out_en", i, int'(oe[i]), int'(en));
            if (en) chk("out_data", i, int'(dout[i]), pad ? 0 : int'(tab[i][m_pix[i]]));

            if (wv_o[i]) begin
                idx = -1;
                foreach (exp_q[j]) if (idx < 0 && int'(exp_q[j][15:14]) == i) idx = j;
                chk("win_expected", i, int'(idx >= 0), 1);
                if (idx >= 0) begin
                    chk("sb_row", i, o_wr[i], int'(exp_q[idx][13:7]));
                    chk("sb_col", i, o_wc[i], int'(exp_q[idx][6:0]));
                    exp_q.delete(idx);
                end
                wcnt[i]++;
            end
            if (fd_o[i]) begin
                left = 0;
                foreach (exp_q[j]) if (int'(exp_q[j][15:14]) == i) left++;
                chk("win_count", i, wcnt[i], wo * ho);
                chk("sb_drained", i, left, 0);
            end

            nwv = en && (m_r[i] >= p_k[i] - 1) && (m_c[i] >= p_k[i] - 1) &&
                  ((m_r[i] - p_k[i] + 1) % p_s[i] == 0) && ((m_c[i] - p_k[i] + 1) % p_s[i] == 0);
            m_wv[i] = nwv;
            if (nwv) begin
                m_wr[i] = (m_r[i] - p_k[i] + 1) / p_s[i];
                m_wc[i] = (m_c[i] - p_k[i] + 1) / p_s[i];
            end
            m_fd[i] = en && (m_r[i] == hp - 1) && (m_c[i] == wp - 1);
            if (en) begin
                if (!pad) m_pix[i]++;
                if (m_c[i] == wp - 1) begin
                    m_c[i] = 0;
                    m_r[i] = (m_r[i] == hp - 1) ? 0 : m_r[i] + 1;
                end else begin
                    m_c[i]++;
                end
            end
            if (m_act[i]) begin
                if (m_fd[i]) m_act[i] = 0;
            end else if (st) begin
                m_act[i] = 1; m_r[i] = 0; m_c[i] = 0; m_pix[i] = 0; wcnt[i] = 0;
                for (int k = 0; k < 64; k++) tab[i][k] = 8'($urandom);
                for (int orow = 0; orow < ho; orow++)
                    for (int ocol = 0; ocol < wo; ocol++)
                        exp_q.push_back({2'(i), 7'(orow), 7'(ocol)});
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && n < budget) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("frame_timeout", 0, int'(m_act[0] || m_act[1] || m_act[2]), 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        int n;
        n_assert = 0; n_fail = 0; cyc = 0; rand_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; din[i] = '0; vmode[i] = 0;
        end
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Frame 1: continuous input on the padded configs, toggling valid on P=0
        vmode[2] = 1;
        step(1'b1, 1'b1);
        run_until_idle(400);

        // Frame 2: stall three cycles mid row 3, and a start while busy
        step(1'b1, 1'b1);
        repeat (19) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        run_until_idle(400);

        // Random traffic with back-to-back frames off the first config's frame_done
        vmode[0] = 2; vmode[1] = 2; vmode[2] = 2;
        rand_rdy = 1;
        step(1'b1, 1'b1);
        n = 0;
        while (!m_fd[0] && n < 400) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("fd_timeout", 0, int'(m_fd[0]), 1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        run_until_idle(600);

        // Asynchronous reset between edges in mid-frame, then a full replay
        step(1'b1, 1'b1);
        repeat (15) step(1'b0, 1'b1);
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1);
        run_until_idle(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
